mvu_acc_out_stream: RTL and testbench
=====================================

// Module: mvu_acc_out_stream
//
// PURPOSE
// Consumer side of the PE accumulator outputs. Captures one word of PE
// parallel accumulator results on every in_acc_v pulse, buffers it in a
// FIFO, and streams it downstream on a valid/ready interface with
// backpressure. Raises almost_full so the MVU control can hold sf_clr before
// results are lost, and flags any result that arrives while the FIFO is full.
//
// PARAMETERS
// PE         2   number of PEs; lanes per output word
// TDstI      16  accumulator word length per PE lane
// DEPTH      4   FIFO depth in words; power of two, >= 2
// AF_MARGIN  1   almost_full asserts when occupancy >= DEPTH-AF_MARGIN; 0..DEPTH-1
//
// PORTS
// clk       in   1                   main clock
// rst       in   1                   synchronous reset, active high
// in_acc_v  in   1                   accumulator result valid, one pulse per result word
// in_acc    in   PE*TDstI            PE accumulator outputs; lane p = [p*TDstI +: TDstI]
// out_v     out  1                   output word valid
// out_rdy   in   1                   downstream ready
// out_dat   out  PE*TDstI            output word; same lane order as in_acc
// occ       out  $clog2(DEPTH+1)     current FIFO occupancy, 0..DEPTH
// almost_full out 1                  occ >= DEPTH-AF_MARGIN (registered view of occ)
// ovf_err   out  1                   sticky: a result was dropped because the FIFO was full
//
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: occ=0, out_v=0, out_dat=0, almost_full=0, ovf_err=0; rd/wr pointers=0.
//   Reset mid-operation flushes all buffered words; in_acc_v in a reset cycle is ignored.
// - push = in_acc_v && (occ<DEPTH || pop). pop = out_v && out_rdy.
// - Storage: DEPTH x (PE*TDstI) array; wr/rd pointers wrap modulo DEPTH.
// - Data is passed through bit-exact; no arithmetic, no lane reorder, no sign change.
// - Latency: word pushed at edge N appears on out_dat with out_v=1 after edge N
//   if the FIFO was empty (out_v visible in cycle N+1). No combinational in->out path.
// - out_v == (occ != 0). out_dat = head word; stable while out_v && !out_rdy.
// - Simultaneous push+pop: occ unchanged; allowed at occ=DEPTH (pop frees slot the
//   same edge) and at occ=1 (new word becomes head the cycle after old head leaves).
// - Push at occ=DEPTH without pop: word dropped, occ stays DEPTH, ovf_err set to 1
//   at that edge and held until rst. Buffered words are not disturbed.
// - Pop at occ=0 cannot occur (out_v=0); out_rdy ignored when out_v=0.
// - occ and almost_full are registered; almost_full updates same edge as occ.
// - out_rdy may toggle any cycle, including held low indefinitely; no word is
//   duplicated or skipped.
//
// TESTING
// 1 Reset then 3 pulses in_acc_v with in_acc=0x0001_0002,0x0003_0004,0x0005_0006,
//   out_rdy=1 -> out_dat shows same 3 words in order, out_v 1 cycle after each push.
// 2 out_rdy=0, push 4 words (DEPTH=4) -> occ=4, almost_full=1 from occ=3,
//   ovf_err=0; 5th push -> ovf_err=1, occ=4; release out_rdy -> first 4 words only.
// 3 occ=4, push and out_rdy=1 same cycle -> occ stays 4, no ovf_err, new word
//   emerges last; drain yields 4 words then out_v=0.
// 4 Random out_rdy (50%) with 200 pushes, push only when !almost_full -> scoreboard
//   matches 200 words in order, ovf_err=0, out_dat stable whenever stalled.
// 5 occ=3, assert rst 1 cycle with in_acc_v=1 -> next cycle occ=0, out_v=0,
//   out_dat=0, ovf_err=0; following push works normally.
// 6 Lane check PE=4,TDstI=8: in_acc=0x80FF_017F -> out_dat=0x80FF_017F exactly.

Source files
------------

// File: rtl/mvu_acc_out_stream.sv
// Output stream buffer for PE accumulator results: captures one word per in_acc_v pulse into a
// FIFO and presents it downstream on a valid/ready interface with occupancy and overflow flags.
module mvu_acc_out_stream #(
   parameter int unsigned PE        = 2,
   parameter int unsigned TDstI     = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned AF_MARGIN = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_acc_v,
   input  logic [PE*TDstI-1:0]          in_acc,
   output logic                         out_v,
   input  logic                         out_rdy,
   output logic [PE*TDstI-1:0]          out_dat,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         almost_full,
   output logic                         ovf_err
);

   localparam int unsigned W    = PE * TDstI;
   localparam int unsigned OccW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);
   localparam logic [OccW-1:0] AfThresh = OccW'(DEPTH - AF_MARGIN);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [OccW-1:0] occ_q, occ_d;
   logic            af_q, af_d;
   logic            ovf_q, ovf_d;
   logic            push, pop, full;

   always_comb begin
      pop   = (occ_q != '0) && out_rdy;
      full  = (occ_q == DepthOcc);
      // A pop frees the slot on the same edge, so a full FIFO still accepts push+pop.
      push  = in_acc_v && (!full || pop);
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + OccW'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - OccW'(1);
      end
      af_d  = (occ_d >= AfThresh);
      ovf_d = ovf_q | (in_acc_v & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
         af_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + PtrW'(1);
         if (pop)  rd_q <= rd_q + PtrW'(1);
         occ_q <= occ_d;
         af_q  <= af_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_q] <= in_acc;
      end
   end

   always_comb begin
      out_v       = (occ_q != '0);
      out_dat     = out_v ? mem_q[rd_q] : '0;
      occ         = occ_q;
      almost_full = af_q;
      ovf_err     = ovf_q;
   end

endmodule

// File: tb/tb_mvu_acc_out_stream.sv
// Scoreboard bench for mvu_acc_out_stream: a reference occupancy model and an expected-word queue
// are updated as stimulus is driven and compared against the DUT every cycle.
module tb_mvu_acc_out_stream;

   localparam int unsigned Depth = 4;
   localparam int unsigned AfMargin = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_acc_v;
   logic [31:0] in_acc;
   logic        out_v;
   logic        out_rdy;
   logic [31:0] out_dat;
   logic [2:0]  occ;
   logic        almost_full;
   logic        ovf_err;

   logic        lane_v, lane_rdy, lane_out_v, lane_af, lane_ovf;
   logic [31:0] lane_in, lane_out;
   logic [2:0]  lane_occ;

   always #5 clk = ~clk;

   mvu_acc_out_stream #(.PE(2), .TDstI(16), .DEPTH(Depth), .AF_MARGIN(AfMargin)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_acc_v    (in_acc_v),
      .in_acc      (in_acc),
      .out_v       (out_v),
      .out_rdy     (out_rdy),
      .out_dat     (out_dat),
      .occ         (occ),
      .almost_full (almost_full),
      .ovf_err     (ovf_err)
   );

   mvu_acc_out_stream #(.PE(4), .TDstI(8), .DEPTH(Depth), .AF_MARGIN(AfMargin)) u_dut_lane (
      .clk         (clk),
      .rst         (rst),
      .in_acc_v    (lane_v),
      .in_acc      (lane_in),
      .out_v       (lane_out_v),
      .out_rdy     (lane_rdy),
      .out_dat     (lane_out),
      .occ         (lane_occ),
      .almost_full (lane_af),
      .ovf_err     (lane_ovf)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   int          m_occ = 0;
   logic        m_ovf = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_dat = '0;
   int          n_pushed = 0;
   int          n_popped = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Compare at negedge, update the model with the stimulus, then advance past the posedge.
   task automatic step();
      logic        pop_m, push_m;
      logic [31:0] exp_w;
      @(negedge clk);
      check_eq("out_v", {31'd0, out_v}, {31'd0, m_occ != 0});
      check_eq("occ", {29'd0, occ}, m_occ);
      check_eq("almost_full", {31'd0, almost_full}, {31'd0, m_occ >= int'(Depth - AfMargin)});
      check_eq("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
      if (stall_prev) check_eq("stall_stable", out_dat, prev_dat);
      pop_m = (m_occ != 0) && out_rdy;
      if (pop_m) begin
         exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check_eq("out_dat", out_dat, exp_w);
         n_popped++;
      end
      stall_prev = (m_occ != 0) && !out_rdy;
      prev_dat   = out_dat;
      if (rst) begin
         exp_q.delete();
         m_occ = 0;
         m_ovf = 1'b0;
         stall_prev = 1'b0;
      end else begin
         push_m = in_acc_v && (m_occ < int'(Depth) || pop_m);
         if (push_m) begin
            exp_q.push_back(in_acc);
            n_pushed++;
         end
         if (in_acc_v && !push_m) m_ovf = 1'b1;
         m_occ = m_occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      in_acc_v = 1'b1;
      in_acc   = w;
      step();
      in_acc_v = 1'b0;
   endtask

   task automatic drain();
      out_rdy = 1'b1;
      for (int i = 0; i < 20 && m_occ != 0; i++) step();
      check_eq("drained", m_occ, 0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_acc_v = 1'b0; in_acc = '0; out_rdy = 1'b0;
      lane_v = 1'b0; lane_in = '0; lane_rdy = 1'b1;
      @(posedge clk); #1;
      do_reset();
      check_eq("rst_out_dat", out_dat, 32'h0);

      // In-order pass-through with ready held high.
      out_rdy = 1'b1;
      push_word(32'h0001_0002);
      push_word(32'h0003_0004);
      push_word(32'h0005_0006);
      drain();

      // Fill under backpressure, then overflow.
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + i);
      check_eq("full_occ", {29'd0, occ}, 4);
      check_eq("full_ovf", {31'd0, ovf_err}, 0);
      push_word(32'hBAD0_0005);
      check_eq("ovf_set", {31'd0, ovf_err}, 1);
      check_eq("ovf_occ", {29'd0, occ}, 4);
      drain();
      check_eq("ovf_sticky", {31'd0, ovf_err}, 1);
      do_reset();

      // Push and pop on the same edge while full.
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + i);
      out_rdy = 1'b1;
      push_word(32'hC000_0004);
      out_rdy = 1'b0;
      check_eq("pp_occ", {29'd0, occ}, 4);
      check_eq("pp_ovf", {31'd0, ovf_err}, 0);
      step();
      drain();

      // Random backpressure, producer throttled by almost_full.
      do_reset();
      n_pushed = 0;
      for (int i = 0; i < 3000 && n_pushed < 200; i++) begin
         out_rdy  = 1'($urandom_range(0, 1));
         in_acc_v = !almost_full;
         in_acc   = $urandom();
         step();
      end
      in_acc_v = 1'b0;
      check_eq("rand_pushed", n_pushed, 200);
      drain();
      check_eq("rand_ovf", {31'd0, ovf_err}, 0);

      // Reset mid-operation with a push in the reset cycle.
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) push_word(32'hE000_0000 + i);
      in_acc_v = 1'b1; in_acc = 32'hEEEE_EEEE;
      do_reset();
      in_acc_v = 1'b0;
      check_eq("mid_rst_occ", {29'd0, occ}, 0);
      check_eq("mid_rst_out_v", {31'd0, out_v}, 0);
      check_eq("mid_rst_out_dat", out_dat, 32'h0);
      check_eq("mid_rst_ovf", {31'd0, ovf_err}, 0);
      push_word(32'h1234_5678);
      drain();

      // Lane ordering with PE=4, TDstI=8.
      lane_v = 1'b1; lane_in = 32'h80FF_017F;
      @(posedge clk); #1;
      lane_v = 1'b0;
      check_eq("lane_out_v", {31'd0, lane_out_v}, 1);
      check_eq("lane_out_dat", lane_out, 32'h80FF_017F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
